// File: rtl/aes_fifo_pkg.sv
// aes_fifo_pkg: word/block widths and types shared by the AES input and output FIFOs
package aes_fifo_pkg;
  localparam int WORD_W = 32;
  localparam int BLOCK_W = 128;
  localparam int WORDS_PER_BLOCK = 4;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BLOCK_W-1:0] block_t;
endpackage

// File: rtl/fifo_in_block_store.sv
// block_store: circular buffer of complete 128-bit blocks with push/pop/clear and head output
module block_store
  import aes_fifo_pkg::*;
#(
  parameter int N = 2,
  localparam int CW = $clog2(N + 1),
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pop,
  input  block_t        i_din,
  output block_t        o_head,
  output logic [CW-1:0] o_count
);
  block_t        r_mem [N];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(N - 1) ? '0 : p + 1'b1;
  endfunction
  // guard here too so the buffer never corrupts itself even if a caller misbehaves
  assign w_push  = i_push && r_cnt != CW'(N);
  assign w_pop   = i_pop && r_cnt != '0;
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (rst || i_clear) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= nxt(r_wp);
      end
      if (w_pop) r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/fifo_in.sv
// fifo_in: assembles APB 32-bit writes (MS word first) into 128-bit blocks for the AES core.
// Define FIFO_IN_ERR_EN to add the sticky overflow_err output.
module fifo_in
  import aes_fifo_pkg::*;
#(
  parameter int NUM_BLOCKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write_en,
  input  word_t      data_in,
  input  logic       clear,
  input  logic       block_ready,
  output block_t     block_out,
  output logic       block_valid,
  output logic [1:0] word_count,
  output logic       fifo_empty,
  output logic       fifo_full
`ifdef FIFO_IN_ERR_EN
  ,
  output logic       overflow_err
`endif
);
  localparam int CW = $clog2(NUM_BLOCKS + 1);
  logic [95:0]   r_asm;
  logic [1:0]    r_wc;
  logic [CW-1:0] w_count;
  logic          w_accept, w_push;
  logic [6:0]    w_lo;
  assign block_valid = w_count != '0;
  assign fifo_full   = w_count == CW'(NUM_BLOCKS);
  assign fifo_empty  = !block_valid && r_wc == 2'd0;
  assign word_count  = r_wc;
  // full is judged on registered state, so a 4th word racing a pop is still dropped
  assign w_accept    = write_en && !fifo_full;
  assign w_push      = w_accept && r_wc == 2'd3;
  assign w_lo        = {2'd2 - r_wc, 5'd0};
  always_ff @(posedge clk)
    if (rst || clear) begin
      r_asm <= '0;
      r_wc  <= '0;
    end else if (w_accept) begin
      if (r_wc != 2'd3) r_asm[w_lo +: WORD_W] <= data_in;
      r_wc <= r_wc + 2'd1;
    end
  block_store #(.N(NUM_BLOCKS)) u_store (
    .clk     (clk),
    .rst     (rst),
    .i_clear (clear),
    .i_push  (w_push),
    .i_pop   (block_ready),
    .i_din   ({r_asm, data_in}),
    .o_head  (block_out),
    .o_count (w_count)
  );
`ifdef FIFO_IN_ERR_EN
  always_ff @(posedge clk)
    if (rst || clear) overflow_err <= 1'b0;
    else if (write_en && fifo_full) overflow_err <= 1'b1;
`endif
endmodule

// File: tb/tb_fifo_in.sv
// tb_fifo_in: table vectors, directed corner sequences and random traffic against a queue model of fifo_in
module tb_fifo_in;
  localparam int NB = 2;
  logic         clk = 1'b0;
  logic         rst, clear, write_en, block_ready;
  logic [31:0]  data_in;
  logic [127:0] block_out;
  logic         block_valid, fifo_empty, fifo_full;
  logic [1:0]   word_count;
`ifdef FIFO_IN_ERR_EN
  logic         overflow_err;
`endif
  int checks = 0, errors = 0;
  logic [127:0] m_q[$];
  logic [31:0]  m_w[3];
  int           m_wc = 0;
  bit           m_err = 0;
  always #5 clk = ~clk;
  fifo_in #(.NUM_BLOCKS(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .write_en    (write_en),
    .data_in     (data_in),
    .clear       (clear),
    .block_ready (block_ready),
    .block_out   (block_out),
    .block_valid (block_valid),
    .word_count  (word_count),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full)
`ifdef FIFO_IN_ERR_EN
    ,
    .overflow_err(overflow_err)
`endif
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic model(input bit r, input bit c, input bit we, input logic [31:0] d, input bit rdy);
    bit full;
    full = m_q.size() == NB;
    if (r || c) begin
      m_q.delete();
      m_wc  = 0;
      m_err = 0;
    end else begin
      if (we && full) m_err = 1;
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (we && !full) begin
        if (m_wc == 3) m_q.push_back({m_w[0], m_w[1], m_w[2], d});
        else m_w[m_wc] = d;
        m_wc = (m_wc + 1) % 4;
      end
    end
  endtask
  task automatic cmp(input string tag);
    chk({tag, " word_count"}, 128'(word_count), 128'(m_wc));
    chk({tag, " block_valid"}, 128'(block_valid), 128'(m_q.size() != 0));
    chk({tag, " fifo_empty"}, 128'(fifo_empty), 128'(m_q.size() == 0 && m_wc == 0));
    chk({tag, " fifo_full"}, 128'(fifo_full), 128'(m_q.size() == NB));
    if (m_q.size() != 0) chk({tag, " block_out"}, block_out, m_q[0]);
`ifdef FIFO_IN_ERR_EN
    chk({tag, " overflow_err"}, 128'(overflow_err), 128'(m_err));
`endif
  endtask
  task automatic cyc(input string tag, input bit r, input bit c, input bit we, input logic [31:0] d, input bit rdy);
    rst = r; clear = c; write_en = we; data_in = d; block_ready = rdy;
    @(posedge clk);
    model(r, c, we, d, rdy);
    #1;
    cmp(tag);
  endtask
  task automatic wr(input string tag, input logic [31:0] d);
    cyc(tag, 0, 0, 1, d, 0);
  endtask
  typedef struct {
    bit r, c, we, rdy;
    logic [31:0] d;
    logic [1:0] wc;
    bit v, e, f, co;
    logic [127:0] out;
  } vec_t;
  vec_t tv[6];
  localparam logic [127:0] BLK1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  initial begin
    tv[0] = '{1, 0, 0, 0, 32'h0,        2'd0, 0, 1, 0, 1, 128'h0};
    tv[1] = '{0, 0, 1, 0, 32'h00112233, 2'd1, 0, 0, 0, 0, 128'h0};
    tv[2] = '{0, 0, 1, 0, 32'h44556677, 2'd2, 0, 0, 0, 0, 128'h0};
    tv[3] = '{0, 0, 1, 0, 32'h8899AABB, 2'd3, 0, 0, 0, 0, 128'h0};
    tv[4] = '{0, 0, 1, 0, 32'hCCDDEEFF, 2'd0, 1, 0, 0, 1, BLK1};
    tv[5] = '{0, 0, 0, 0, 32'h0,        2'd0, 1, 0, 0, 1, BLK1};
    for (int i = 0; i < 6; i++) begin
      cyc($sformatf("vec%0d", i), tv[i].r, tv[i].c, tv[i].we, tv[i].d, tv[i].rdy);
      chk($sformatf("vec%0d wc", i), 128'(word_count), 128'(tv[i].wc));
      chk($sformatf("vec%0d valid", i), 128'(block_valid), 128'(tv[i].v));
      chk($sformatf("vec%0d empty", i), 128'(fifo_empty), 128'(tv[i].e));
      chk($sformatf("vec%0d full", i), 128'(fifo_full), 128'(tv[i].f));
      if (tv[i].co) chk($sformatf("vec%0d out", i), block_out, tv[i].out);
    end
    // overflow: 8 words fill both slots, 9th is dropped
    cyc("ovf rst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) wr("ovf wr", 32'h11111111 * (i + 1));
    chk("ovf full after 8", 128'(fifo_full), 128'(1));
    wr("ovf 9th", 32'hDEADBEEF);
    chk("ovf wc stays 0", 128'(word_count), 128'(0));
    chk("ovf still full", 128'(fifo_full), 128'(1));
    chk("ovf head is first block", block_out, 128'h11111111_22222222_33333333_44444444);
`ifdef FIFO_IN_ERR_EN
    chk("ovf err set", 128'(overflow_err), 128'(1));
`endif
    // pop while full and a write arrives: pop happens, word dropped
    cyc("popfull", 0, 0, 1, 32'hCAFEF00D, 1);
    chk("popfull full", 128'(fifo_full), 128'(0));
    chk("popfull wc", 128'(word_count), 128'(0));
    chk("popfull head", block_out, 128'h55555555_66666666_77777777_88888888);
    // back-to-back drain
    cyc("drain rst", 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) wr("drain wr", 32'hA0000000 + i);
    chk("drain head A", block_out, 128'hA0000000_A0000001_A0000002_A0000003);
    cyc("drain pop1", 0, 0, 0, 0, 1);
    chk("drain head B", block_out, 128'hA0000004_A0000005_A0000006_A0000007);
    chk("drain valid after pop1", 128'(block_valid), 128'(1));
    cyc("drain pop2", 0, 0, 0, 0, 1);
    chk("drain valid after pop2", 128'(block_valid), 128'(0));
    chk("drain empty", 128'(fifo_empty), 128'(1));
    cyc("drain idle ready", 0, 0, 0, 0, 1);
    // clear beats a simultaneous write
    wr("clr wr", 32'h01010101);
    wr("clr wr", 32'h02020202);
    cyc("clr", 0, 1, 1, 32'h03030303, 0);
    chk("clr wc", 128'(word_count), 128'(0));
    chk("clr empty", 128'(fifo_empty), 128'(1));
    for (int i = 0; i < 4; i++) wr("clr fresh", 32'hB0000000 + i);
    chk("clr fresh block", block_out, 128'hB0000000_B0000001_B0000002_B0000003);
    // mid-stream reset
    for (int i = 0; i < 3; i++) wr("mrst wr", 32'hC0000000 + i);
    cyc("mrst", 1, 0, 0, 0, 0);
    chk("mrst out", block_out, 128'h0);
    chk("mrst valid", 128'(block_valid), 128'(0));
    chk("mrst empty", 128'(fifo_empty), 128'(1));
    cyc("mrst after", 0, 0, 0, 0, 1);
    chk("mrst no stale", 128'(block_valid), 128'(0));
    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc("rnd", $urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0,
          $urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 2) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
